// File: rtl/encrypt_config.sv
// Shared types and defaults for the encrypt pipeline's XOR-key stage.
package encrypt_config;

  localparam int KEY_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    XK_IDLE = 2'd0,
    XK_LOAD = 2'd1,
    XK_RUN  = 2'd2
  } xor_key_state_t;

  typedef logic [7:0] byte_t;

  function automatic byte_t rol1(input byte_t b);
    return {b[6:0], b[7]};
  endfunction

endpackage

// File: rtl/encrypt_key_bank.sv
// Key register file for the XOR-key stage: serial write port, indexed read mux.
// Optional XOR_KEY_ROLL_EN rotates every key byte left by 1 bit on each index wrap.
module encrypt_key_bank
  import encrypt_config::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF,
  parameter int IDX_W     = $clog2(KEY_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [7:0]       wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             xor_fire_i,
  output logic [7:0]       rd_data_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES - 1);

  byte_t bank_q [KEY_BYTES];
  byte_t bank_d [KEY_BYTES];
  logic  roll_s;

`ifdef XOR_KEY_ROLL_EN
  assign roll_s = xor_fire_i && (rd_idx_i == LAST_IDX);
`else
  logic unused_roll_s;
  assign unused_roll_s = xor_fire_i;
  assign roll_s        = 1'b0;
`endif

  // Roll and write never coincide: writes happen only while loading, XORs only in run.
  always_comb begin
    for (int k = 0; k < KEY_BYTES; k++) begin
      bank_d[k] = bank_q[k];
    end
    if (roll_s) begin
      for (int k = 0; k < KEY_BYTES; k++) begin
        bank_d[k] = rol1(bank_q[k]);
      end
    end else if (wr_en_i) begin
      bank_d[wr_idx_i] = wr_data_i;
    end else begin
      bank_d[0] = bank_q[0];
    end
  end

  // Key storage register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < KEY_BYTES; k++) begin
        bank_q[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < KEY_BYTES; k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/encrypt_pipe_xor_key.sv
// Final encrypt stage: XORs each valid byte with a rotating key under a 3-state FSM.
// Build option XOR_KEY_ROLL_EN enables per-wrap key rotation inside encrypt_key_bank.
module encrypt_pipe_xor_key
  import encrypt_config::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic [7:0] data_in,
  input  logic       key_load_start,
  input  logic       key_valid,
  input  logic [7:0] key_byte,
  output logic       en_out,
  output logic [7:0] data_out,
  output logic       key_ready
);

  localparam int               IDX_W    = $clog2(KEY_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES - 1);

  xor_key_state_t   state_q, state_d;
  logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0] key_idx_q, key_idx_d;
  logic             en_out_q, key_ready_q;
  logic [7:0]       data_out_q, data_out_d;
  logic             wr_en_s, xor_fire_s;
  logic [7:0]       key_s;

  encrypt_key_bank #(
    .KEY_BYTES (KEY_BYTES),
    .IDX_W     (IDX_W)
  ) u_key_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (load_cnt_q),
    .wr_data_i  (key_byte),
    .rd_idx_i   (key_idx_q),
    .xor_fire_i (xor_fire_s),
    .rd_data_o  (key_s)
  );

  assign xor_fire_s = en && mode && (state_q == XK_RUN);

  // Next state, load counter, key index and key write strobe.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    key_idx_d  = key_idx_q;
    wr_en_s    = 1'b0;
    if (xor_fire_s) begin
      key_idx_d = (key_idx_q == LAST_IDX) ? '0 : key_idx_q + IDX_W'(1);
    end else begin
      key_idx_d = key_idx_q;
    end
    case (state_q)
      XK_IDLE: state_d = XK_IDLE;
      XK_LOAD: begin
        // A start pulse in the same cycle restarts the load, so that byte is dropped.
        if (key_valid && !key_load_start) begin
          wr_en_s = 1'b1;
          if (load_cnt_q == LAST_IDX) begin
            state_d   = XK_RUN;
            key_idx_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + IDX_W'(1);
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      XK_RUN:  state_d = XK_RUN;
      default: state_d = XK_IDLE;
    endcase
    if (key_load_start) begin
      state_d    = XK_LOAD;
      load_cnt_d = '0;
    end else begin
      load_cnt_d = load_cnt_d;
    end
  end

  // Output byte: ciphertext only once a key is installed and mode selects encrypt.
  always_comb begin
    data_out_d = 8'h00;
    if (!en) begin
      data_out_d = 8'h00;
    end else if (xor_fire_s) begin
      data_out_d = data_in ^ key_s;
    end else begin
      data_out_d = data_in;
    end
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= XK_IDLE;
      load_cnt_q  <= '0;
      key_idx_q   <= '0;
      en_out_q    <= 1'b0;
      data_out_q  <= 8'h00;
      key_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      key_idx_q   <= key_idx_d;
      en_out_q    <= en;
      data_out_q  <= data_out_d;
      key_ready_q <= (state_d == XK_RUN);
    end
  end

  assign en_out    = en_out_q;
  assign data_out  = data_out_q;
  assign key_ready = key_ready_q;

endmodule

// File: tb/tb_encrypt_pipe_xor_key.sv
// Scoreboard bench for encrypt_pipe_xor_key: directed scenarios plus random traffic
// checked against a behavioural key/cipher model.
module tb_encrypt_pipe_xor_key;

  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, mode = 1'b0, key_load_start = 1'b0, key_valid = 1'b0;
  logic [7:0] data_in = 8'h00, key_byte = 8'h00;
  logic       en_out, key_ready;
  logic [7:0] data_out;

  encrypt_pipe_xor_key #(.KEY_BYTES(K)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mode           (mode),
    .data_in        (data_in),
    .key_load_start (key_load_start),
    .key_valid      (key_valid),
    .key_byte       (key_byte),
    .en_out         (en_out),
    .data_out       (data_out),
    .key_ready      (key_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [7:0] d;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state
  logic [7:0] m_key [K];
  bit         m_have_key;
  bit         m_loading;
  int         m_cnt;
  int         m_idx;

  task automatic model_reset();
    for (int k = 0; k < K; k++) m_key[k] = 8'h00;
    m_have_key = 1'b0;
    m_loading  = 1'b0;
    m_cnt      = 0;
    m_idx      = 0;
  endtask

  // Monitor: one response per cycle, compared against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if ({en_out, data_out, key_ready} !== e) begin
        n_fail++;
        $display("FAIL out@%0d: got en_out=%0b data_out=%02h key_ready=%0b, need en_out=%0b data_out=%02h key_ready=%0b",
                 cyc, en_out, data_out, key_ready, e.en, e.d, e.rdy);
      end
    end
  end

  task automatic step(input logic i_en, input logic i_mode, input logic [7:0] i_d,
                      input logic i_st, input logic i_kv, input logic [7:0] i_kb,
                      input logic use_c, input logic [7:0] c_d);
    exp_t e;
    @(negedge clk);
    en = i_en; mode = i_mode; data_in = i_d;
    key_load_start = i_st; key_valid = i_kv; key_byte = i_kb;
    e.en = i_en;
    if (!i_en)                        e.d = 8'h00;
    else if (i_mode && m_have_key)    e.d = i_d ^ m_key[m_idx];
    else                              e.d = i_d;
    if (use_c) e.d = c_d;
    if (i_en && i_mode && m_have_key) begin
`ifdef XOR_KEY_ROLL_EN
      if (m_idx == K - 1)
        for (int k = 0; k < K; k++) m_key[k] = {m_key[k][6:0], m_key[k][7]};
`endif
      m_idx = (m_idx + 1) % K;
    end
    if (i_st) begin
      m_have_key = 1'b0;
      m_loading  = 1'b1;
      m_cnt      = 0;
    end else if (m_loading && i_kv) begin
      m_key[m_cnt] = i_kb;
      if (m_cnt == K - 1) begin
        m_loading  = 1'b0;
        m_have_key = 1'b1;
        m_idx      = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.rdy = m_have_key;
    q.push_back(e);
  endtask

  task automatic dat(input logic i_en, input logic i_mode, input logic [7:0] i_d);
    step(i_en, i_mode, i_d, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic dat_c(input logic [7:0] i_d, input logic [7:0] c_d);
    step(1'b1, 1'b1, i_d, 1'b0, 1'b0, 8'h00, 1'b1, c_d);
  endtask

  task automatic kbyte(input logic [7:0] b);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, b, 1'b0, 8'h00);
  endtask

  task automatic start();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (en_out !== 1'b0 || data_out !== 8'h00 || key_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got en_out=%0b data_out=%02h key_ready=%0b, need all zero",
               name, en_out, data_out, key_ready);
    end
  endtask

  initial begin
    int r;
    logic [7:0] rd, rk;
    model_reset();
    @(negedge clk);
    #2;
    check_zero("reset");
    rst = 1'b1;

    // Bypass without key; key_valid in IDLE ignored
    dat_c(8'h41, 8'h41);
    kbyte(8'h99);
    dat_c(8'h41, 8'h41);

    // Load 11..44; data during final write is bypassed
    start();
    kbyte(8'h11); kbyte(8'h22); kbyte(8'h33);
    step(1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 8'h44, 1'b1, 8'h41);
    dat_c(8'h41, 8'h50); dat_c(8'h41, 8'h63); dat_c(8'h41, 8'h72); dat_c(8'h41, 8'h05);
`ifdef XOR_KEY_ROLL_EN
    dat_c(8'h41, 8'h63);
`else
    dat_c(8'h41, 8'h50);
`endif

    // Mode 0 and gaps do not advance the key index
    start();
    kbyte(8'h11); kbyte(8'h22); kbyte(8'h33); kbyte(8'h44);
    dat_c(8'h00, 8'h11);
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A);
    dat(1'b0, 1'b1, 8'hFF);
    dat_c(8'h00, 8'h22);
    dat(1'b0, 1'b0, 8'h3C);
    dat_c(8'h00, 8'h33);
    dat_c(8'h00, 8'h44);

    // Restart mid-load
    start(); kbyte(8'hAA); kbyte(8'hBB);
    start(); kbyte(8'h01); kbyte(8'h02); kbyte(8'h03); kbyte(8'h04);
    dat_c(8'h00, 8'h01); dat_c(8'h00, 8'h02); dat_c(8'h00, 8'h03); dat_c(8'h00, 8'h04);

    // Start and key_valid together in RUN: byte dropped, four more writes needed
    step(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
    kbyte(8'hC0); kbyte(8'hC1); kbyte(8'hC2);
    dat(1'b1, 1'b1, 8'h0F);
    kbyte(8'hC3);
    dat(1'b1, 1'b1, 8'h00); dat(1'b1, 1'b1, 8'h00);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 99));
      rd = 8'($urandom);
      rk = 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), rd,
           1'(r < 3), 1'($urandom_range(0, 1)), rk, 1'b0, 8'h00);
    end

    // Async reset between edges during an encrypt burst
    start();
    kbyte(8'h5A); kbyte(8'hA5); kbyte(8'h3C); kbyte(8'hC3);
    dat(1'b1, 1'b1, 8'h12); dat(1'b1, 1'b1, 8'h34);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    en = 1'b0; key_load_start = 1'b0; key_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    dat_c(8'h41, 8'h41);
    dat_c(8'h99, 8'h99);
    kbyte(8'h01);
    dat_c(8'h77, 8'h77);

    repeat (3) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
